// File: rtl/tcm_arb_pkg.sv
// Shared types and AHB-Lite encodings for the two-port TCM SRAM arbiter.
package tcm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2
  } port_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/tcm_arb_port.sv
// One AHB-Lite slave port: address-phase capture, IDLE/REQ/RDWAIT FSM and
// byte-enable decode. The FSM state is exported for the top and for checkers.
module tcm_arb_port
  import tcm_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel,
  input  logic          hready,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic [AW-1:0] haddr,
  input  logic          grant,
  output logic          req,
  output logic          is_write,
  output logic [AW-3:0] word_addr,
  output logic [3:0]    wen,
  output logic          hreadyout,
  output port_state_e   state
);

  port_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          accept;
  logic          done;
  logic [3:0]    wen_dec;

  assign accept = hsel & hready & (htrans != HTRANS_IDLE) & (htrans != HTRANS_BUSY);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    write_d   = write_q;
    hreadyout = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        if (grant && write_q) begin
          done = 1'b1;
        end else if (grant) begin
          state_d   = ST_RDWAIT;
          hreadyout = 1'b0;
        end else begin
          hreadyout = 1'b0;
        end
      end
      ST_RDWAIT: done = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
    // A new address phase can only be taken while the bus sees us ready.
    if ((state_q == ST_IDLE) || done) begin
      if (accept) begin
        state_d = ST_REQ;
        addr_d  = haddr;
        size_d  = hsize;
        write_d = hwrite;
      end else if (done) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    wen_dec = 4'b0000;
    case (size_q)
      HSIZE_BYTE: wen_dec = 4'b0001 << addr_q[1:0];
      HSIZE_HALF: wen_dec = addr_q[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: wen_dec = 4'b1111;
      default:    wen_dec = 4'b1111;
    endcase
  end

  assign req       = (state_q == ST_REQ);
  assign is_write  = write_q;
  assign word_addr = addr_q[AW-1:2];
  assign wen       = (req && write_q) ? wen_dec : 4'b0000;
  assign state     = state_q;

endmodule

// File: rtl/tcm_sram_arbiter.sv
// Two AHB-Lite ports (instruction i, data d) sharing one single-port SRAM.
// Ties go to the port that was not granted most recently.
module tcm_sram_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel_i,
  input  logic          hready_i,
  input  logic [1:0]    htrans_i,
  input  logic [2:0]    hsize_i,
  input  logic          hwrite_i,
  input  logic [AW-1:0] haddr_i,
  input  logic [31:0]   hwdata_i,
  output logic          hreadyout_i,
  output logic          hresp_i,
  output logic [31:0]   hrdata_i,
  input  logic          hsel_d,
  input  logic          hready_d,
  input  logic [1:0]    htrans_d,
  input  logic [2:0]    hsize_d,
  input  logic          hwrite_d,
  input  logic [AW-1:0] haddr_d,
  input  logic [31:0]   hwdata_d,
  output logic          hreadyout_d,
  output logic          hresp_d,
  output logic [31:0]   hrdata_d,
  output logic          sram_cs,
  output logic [AW-3:0] sram_addr,
  output logic [3:0]    sram_wen,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  logic          req_i, req_d;
  logic          wr_i, wr_d;
  logic [AW-3:0] waddr_i, waddr_d;
  logic [3:0]    wen_i, wen_d;
  logic          gnt_i, gnt_d;
  port_state_e   state_i, state_d;
  grant_e        last_q, last_d;

  tcm_arb_port #(.AW(AW)) u_port_i (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel_i),
    .hready    (hready_i),
    .htrans    (htrans_i),
    .hsize     (hsize_i),
    .hwrite    (hwrite_i),
    .haddr     (haddr_i),
    .grant     (gnt_i),
    .req       (req_i),
    .is_write  (wr_i),
    .word_addr (waddr_i),
    .wen       (wen_i),
    .hreadyout (hreadyout_i),
    .state     (state_i)
  );

  tcm_arb_port #(.AW(AW)) u_port_d (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel_d),
    .hready    (hready_d),
    .htrans    (htrans_d),
    .hsize     (hsize_d),
    .hwrite    (hwrite_d),
    .haddr     (haddr_d),
    .grant     (gnt_d),
    .req       (req_d),
    .is_write  (wr_d),
    .word_addr (waddr_d),
    .wen       (wen_d),
    .hreadyout (hreadyout_d),
    .state     (state_d)
  );

  always_comb begin
    gnt_i  = req_i & (~req_d | (last_q == GNT_D));
    gnt_d  = req_d & ~gnt_i;
    last_d = last_q;
    if (gnt_i) begin
      last_d = GNT_I;
    end else if (gnt_d) begin
      last_d = GNT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end

  // Write data comes straight from the data phase of the granted port.
  always_comb begin
    sram_cs    = 1'b0;
    sram_addr  = '0;
    sram_wen   = 4'b0000;
    sram_wdata = '0;
    if (gnt_i) begin
      sram_cs    = 1'b1;
      sram_addr  = waddr_i;
      sram_wen   = wen_i;
      sram_wdata = wr_i ? hwdata_i : 32'h0;
    end else if (gnt_d) begin
      sram_cs    = 1'b1;
      sram_addr  = waddr_d;
      sram_wen   = wen_d;
      sram_wdata = wr_d ? hwdata_d : 32'h0;
    end
  end

  assign hrdata_i = (state_i == ST_RDWAIT) ? sram_rdata : 32'h0;
  assign hrdata_d = (state_d == ST_RDWAIT) ? sram_rdata : 32'h0;
  assign hresp_i  = 1'b0;
  assign hresp_d  = 1'b0;

endmodule
